// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the digit-serial adder: state encoding and digit width.
package serial_adder_ctrl_pkg;

  // Width of one digit handled by the nibble datapath per clock.
  localparam int NIBBLE_W = 4;

  // Controller states; the unused encoding 2'd3 is steered back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_adder_4.sv
// 4-bit ripple adder: combinational nibble datapath used by the serial controller.
module adder_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] total_s;

  // Full 5-bit sum; the top bit is the carry into the next digit.
  always_comb begin
    total_s = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    sum_o   = total_s[3:0];
    cout_o  = total_s[4];
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Digit-serial multi-nibble adder: latches operands on start, adds one nibble
// per clock LSB first through adder_4, and presents sum/cout with a done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     part_q, part_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W+1:0] nib_idx_s;
  logic [3:0]       nib_a_s;
  logic [3:0]       nib_b_s;
  logic [3:0]       nib_sum_s;
  logic             nib_cout_s;

  // Select the operand digits addressed by the nibble counter.
  always_comb begin
    nib_idx_s = {cnt_q, 2'b00};
    nib_a_s   = a_q[nib_idx_s +: 4];
    nib_b_s   = b_q[nib_idx_s +: 4];
  end

  adder_4 u_adder_4 (
    .a_i    (nib_a_s),
    .b_i    (nib_b_s),
    .cin_i  (carry_q),
    .sum_o  (nib_sum_s),
    .cout_o (nib_cout_s)
  );

  // Next-state and datapath update; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          part_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        part_d[nib_idx_s +: 4] = nib_sum_s;
        carry_d                = nib_cout_s;
        cnt_d                  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Final digit: publish the completed result in the same edge.
          state_d = ST_DONE;
          sum_d   = part_d;
          cout_d  = nib_cout_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (NIBBLES=4).
module tb_serial_adder_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [7];

  serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one accepting edge.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done after an accepting edge and check the result.
  task automatic wait_done(input string name, input logic [W-1:0] es, input logic ec,
                           input bit disturb, input bit chain,
                           input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
    logic [W-1:0] prev;
    int cycles;
    int busy_cnt;
    bit stable;
    prev     = sum;
    cycles   = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (sum !== prev) stable = 1'b0;
      if (disturb) begin
        start = 1'b1;
        a     = 16'hFFFF;
        b     = W'($urandom);
        cin   = 1'b1;
      end
      step();
      cycles++;
    end
    chk({name, " latency"}, cycles, NIB);
    chk({name, " busy_cycles"}, busy_cnt, NIB);
    chk({name, " sum_held_in_run"}, {31'd0, stable}, 32'd1);
    chk({name, " sum"}, {16'd0, sum}, {16'd0, es});
    chk({name, " cout"}, {31'd0, cout}, {31'd0, ec});
    chk({name, " ready_in_done"}, {31'd0, ready}, 32'd1);
    if (chain) begin
      a     = na;
      b     = nb;
      cin   = nc;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({name, " done_single_b2b"}, {31'd0, done}, 32'd0);
      chk({name, " busy_b2b"}, {31'd0, busy}, 32'd1);
    end else begin
      start = 1'b0;
      step();
      chk({name, " done_single"}, {31'd0, done}, 32'd0);
      chk({name, " idle_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int seen_done;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

    step();
    step();
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst sum", {16'd0, sum}, 32'd0);
    chk("rst cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    step();

    // Table of independent additions.
    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].va, vecs[i].vb, vecs[i].vcin);
      wait_done($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout,
                1'b0, 1'b0, '0, '0, 1'b0);
    end

    // Back-to-back: new start held in the DONE cycle.
    launch(16'h7A58, 16'h1234, 1'b1);
    wait_done("b2b_first", 16'h8C8D, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0);
    wait_done("b2b_second", 16'h0002, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Start and operand changes during RUN are ignored.
    launch(16'h1111, 16'h2222, 1'b0);
    wait_done("ignore_run", 16'h3333, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Reset in the second RUN cycle aborts without a done pulse.
    launch(16'h5555, 16'h5555, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort ready", {31'd0, ready}, 32'd1);
    chk("abort sum", {16'd0, sum}, 32'd0);
    chk("abort cout", {31'd0, cout}, 32'd0);
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) seen_done++;
      step();
    end
    chk("abort no_done", seen_done, 0);

    launch(16'h0003, 16'h0004, 1'b0);
    wait_done("after_abort", 16'h0007, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
